score_display_bcd: RTL and testbench

Parametrised successor to the game's score display. Holds a DIGITS-wide packed-BCD score credited by hit pulses from the game logic. It latches a high score at game over and drives a multiplexed, active-low 7-segment display with leading-zero blanking and score/high-score selection. It sits beside the graphic block, fed by the game's destroy pulse, and drives the board's seg/an pins.

---
 rtl/score_display_bcd.sv | 153 +++++++++++++++
 tb/tb_score_display_bcd.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_bcd.sv
// BCD score keeper with high-score latch and a multiplexed, active-low
// 7-segment driver with leading-zero blanking.
module score_display_bcd #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned POINTS = 10,
  parameter int unsigned DWELL  = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hit,
  input  logic                  clear_score,
  input  logic                  game_over,
  input  logic                  show_high,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DWELL);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [7:0]        pending;
  logic [9:0]        pend_sum;
  logic [7:0]        pend_next;
  logic [SW-1:0]     score_inc;
  logic              all_nines;
  logic              carry;
  logic [3:0]        dig;
  logic [CW-1:0]     dwell_cnt;
  logic [IW-1:0]     digit_idx;
  logic [SW-1:0]     src;
  logic [DIGITS-1:0] lit;
  logic              above_nz;
  logic [3:0]        cur_digit;
  logic              cur_lit;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Pending credit: drain one per cycle, add POINTS on hit, saturate at 255.
  always_comb begin
    pend_sum  = 10'(pending) - 10'(pending != 8'd0) + (hit ? 10'(POINTS) : 10'd0);
    pend_next = (pend_sum > 10'd255) ? 8'hFF : pend_sum[7:0];
  end

  // BCD ripple increment of the score; flags the all-nines ceiling.
  always_comb begin
    carry     = 1'b1;
    all_nines = 1'b1;
    dig       = 4'd0;
    score_inc = score_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = score_bcd[4*i +: 4];
      if (dig != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = dig + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Score, pending, overflow and high-score registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_bcd <= '0;
      high_bcd  <= '0;
      pending   <= 8'd0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (game_over && (score_bcd > high_bcd)) high_bcd <= score_bcd;
      if (clear_score) begin
        score_bcd <= '0;
        pending   <= 8'd0;
        busy      <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        pending <= pend_next;
        busy    <= (pend_next != 8'd0);
        if (pending != 8'd0) begin
          if (all_nines) overflow  <= 1'b1;
          else           score_bcd <= score_inc;
        end
      end
    end
  end

  // Display source select, leading-zero blanking and segment decode.
  always_comb begin
    src      = show_high ? high_bcd : score_bcd;
    above_nz = 1'b0;
    lit      = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      above_nz = above_nz | (src[4*i +: 4] != 4'd0);
      lit[i]   = (i == 0) || above_nz;
    end
    cur_digit = 4'd0;
    cur_lit   = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IW'(i) == digit_idx) begin
        cur_digit = src[4*i +: 4];
        cur_lit   = lit[i];
      end
    end
    seg_next = cur_lit ? {1'b1, seg7(cur_digit)} : 8'hFF;
    an_next  = cur_lit ? ~(DIGITS'(1) << digit_idx) : '1;
  end

  // Scan timer, digit index and registered seg/an pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
      digit_idx <= '0;
      seg       <= 8'hFF;
      an        <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      if (dwell_cnt == CNT_MAX) begin
        dwell_cnt <= '0;
        digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_score_display_bcd.sv
// Self-checking bench for score_display_bcd: directed scenarios plus a
// randomized run, all compared against an arithmetic reference model.
module tb_score_display_bcd;

  localparam int unsigned DA = 4, PA = 10, WA = 4;
  localparam int unsigned DB = 2, PB = 255, WB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0, hit = 1'b0, clear_score = 1'b0, game_over = 1'b0, show_high = 1'b0;
  logic hit_b = 1'b0, clear_b = 1'b0, game_over_b = 1'b0, show_high_b = 1'b0;

  logic [7:0]    seg, seg_b;
  logic [DA-1:0] an;
  logic [DB-1:0] an_b;
  logic [15:0]   score_bcd, high_bcd;
  logic [7:0]    score_b, high_b;
  logic          busy, overflow, busy_b, ovf_b;

  int errors = 0;
  int checks = 0;

  score_display_bcd #(.DIGITS(DA), .POINTS(PA), .DWELL(WA)) dut_a (
    .clk(clk), .reset_n(reset_n), .hit(hit), .clear_score(clear_score),
    .game_over(game_over), .show_high(show_high), .seg(seg), .an(an),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .busy(busy), .overflow(overflow));

  score_display_bcd #(.DIGITS(DB), .POINTS(PB), .DWELL(WB)) dut_b (
    .clk(clk), .reset_n(reset_n), .hit(hit_b), .clear_score(clear_b),
    .game_over(game_over_b), .show_high(show_high_b), .seg(seg_b), .an(an_b),
    .score_bcd(score_b), .high_bcd(high_b), .busy(busy_b), .overflow(ovf_b));

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  // Reference model, instance A: integer score/high, cycle-count scan.
  int m_score, m_high, m_pend, m_tick;
  logic m_ovf;
  logic [7:0] m_seg;
  logic [DA-1:0] m_an;
  always @(posedge clk) begin : model_a
    int idx, srcv, p, t;
    if (!reset_n) begin
      m_score <= 0; m_high <= 0; m_pend <= 0; m_ovf <= 1'b0; m_tick <= 0;
      m_seg <= 8'hFF; m_an <= '1;
    end else begin
      idx  = (m_tick / int'(WA)) % int'(DA);
      srcv = show_high ? m_high : m_score;
      p    = pow10(idx);
      if (idx > 0 && srcv < p) begin
        m_seg <= 8'hFF; m_an <= '1;
      end else begin
        m_seg <= SEG_TAB[(srcv / p) % 10];
        m_an  <= ~(DA'(1) << idx);
      end
      m_tick <= m_tick + 1;
      if (game_over && m_score > m_high) m_high <= m_score;
      if (clear_score) begin
        m_score <= 0; m_pend <= 0; m_ovf <= 1'b0;
      end else begin
        if (m_pend > 0) begin
          if (m_score == pow10(DA) - 1) m_ovf <= 1'b1;
          else m_score <= m_score + 1;
        end
        t = m_pend - ((m_pend > 0) ? 1 : 0) + (hit ? int'(PA) : 0);
        m_pend <= (t > 255) ? 255 : t;
      end
    end
  end

  // Reference model, instance B: score/pending/overflow only.
  int mb_score, mb_pend;
  logic mb_ovf;
  always @(posedge clk) begin : model_b
    int t;
    if (!reset_n || clear_b) begin
      mb_score <= 0; mb_pend <= 0; mb_ovf <= 1'b0;
    end else begin
      if (mb_pend > 0) begin
        if (mb_score == pow10(DB) - 1) mb_ovf <= 1'b1;
        else mb_score <= mb_score + 1;
      end
      t = mb_pend - ((mb_pend > 0) ? 1 : 0) + (hit_b ? int'(PB) : 0);
      mb_pend <= (t > 255) ? 255 : t;
    end
  end

  task automatic credit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; @(negedge clk); hit = 1'b0;
      repeat (PA + 1) @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    clear_score = 1'b1; @(negedge clk); clear_score = 1'b0;
  endtask

  task automatic pulse_go();
    game_over = 1'b1; @(negedge clk); game_over = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (an !== 4'hF)   begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (an !== 4'b1110)      begin errors++; $display("FAIL rel_an: got %b want 1110", an); end
    checks++; if (seg !== 8'hC0)       begin errors++; $display("FAIL rel_seg: got %h want c0", seg); end
    checks++; if (score_bcd !== 16'h0) begin errors++; $display("FAIL rel_score: got %h want 0", score_bcd); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rel_busy: got %b want 0", busy); end
    checks++; if (an_b !== 2'b10 || seg_b !== 8'hC0 || high_b !== 8'h00)
      begin errors++; $display("FAIL rel_b: got an=%b seg=%h high=%h want 10 c0 00", an_b, seg_b, high_b); end
  endtask

  task automatic test_single_hit();
    logic [31:0] b32;
    logic [7:0]  seen_seg [DA];
    logic        seen [DA];
    logic [DA-1:0] pat;
    for (int i = 0; i < int'(DA); i++) begin seen[i] = 1'b0; seen_seg[i] = 8'h00; end
    hit = 1'b1; @(negedge clk); hit = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hit_busy_e0: got %b want 1", busy); end
    for (int k = 1; k <= int'(PA); k++) begin
      @(negedge clk);
      b32 = to_bcd(k);
      checks++; if (busy !== (k < int'(PA))) begin errors++; $display("FAIL hit_busy e%0d: got %b want %b", k, busy, k < int'(PA)); end
      checks++; if (score_bcd !== b32[15:0]) begin errors++; $display("FAIL hit_score e%0d: got %h want %h", k, score_bcd, b32[15:0]); end
    end
    checks++; if (score_bcd !== 16'h0010) begin errors++; $display("FAIL hit_final: got %h want 0010", score_bcd); end
    for (int c = 0; c < int'(2 * DA * WA); c++) begin
      @(negedge clk);
      checks++; if (seg !== m_seg || an !== m_an)
        begin errors++; $display("FAIL hit_disp: got seg=%h an=%b want seg=%h an=%b", seg, an, m_seg, m_an); end
      for (int i = 0; i < int'(DA); i++) begin
        pat = ~(DA'(1) << i);
        if (an === pat) begin seen[i] = 1'b1; seen_seg[i] = seg; end
      end
    end
    checks++; if (!seen[1] || seen_seg[1] !== 8'hF9) begin errors++; $display("FAIL hit_digit1: got %h want f9", seen_seg[1]); end
    checks++; if (!seen[0] || seen_seg[0] !== 8'hC0) begin errors++; $display("FAIL hit_digit0: got %h want c0", seen_seg[0]); end
    checks++; if (seen[2] || seen[3]) begin errors++; $display("FAIL hit_blank: got lit2=%b lit3=%b want 0 0", seen[2], seen[3]); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    for (int k = 0; k <= 20; k++) begin
      hit = (k == 0 || k == 3);
      @(negedge clk);
      hit = 1'b0;
      checks++; if (busy !== (k < 20)) begin errors++; $display("FAIL b2b_busy e%0d: got %b want %b", k, busy, k < 20); end
    end
    checks++; if (score_bcd !== 16'h0020) begin errors++; $display("FAIL b2b_score: got %h want 0020", score_bcd); end
    hit = 1'b1; clear_score = 1'b1; @(negedge clk); hit = 1'b0; clear_score = 1'b0;
    checks++; if (score_bcd !== 16'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_clear: got score=%h busy=%b want 0 0", score_bcd, busy); end
    @(negedge clk);
    checks++; if (score_bcd !== 16'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_clear_hold: got score=%h busy=%b want 0 0", score_bcd, busy); end
  endtask

  task automatic test_high_score();
    do_reset();
    credit(3);
    checks++; if (score_bcd !== 16'h0030) begin errors++; $display("FAIL hs_score30: got %h want 0030", score_bcd); end
    pulse_go();
    checks++; if (high_bcd !== 16'h0030) begin errors++; $display("FAIL hs_latch: got %h want 0030", high_bcd); end
    pulse_clear();
    credit(2);
    pulse_go();
    checks++; if (high_bcd !== 16'h0030 || score_bcd !== 16'h0020)
      begin errors++; $display("FAIL hs_keep: got high=%h score=%h want 0030 0020", high_bcd, score_bcd); end
    credit(3);
    clear_score = 1'b1; game_over = 1'b1; @(negedge clk); clear_score = 1'b0; game_over = 1'b0;
    checks++; if (high_bcd !== 16'h0050 || score_bcd !== 16'h0)
      begin errors++; $display("FAIL hs_clear_go: got high=%h score=%h want 0050 0000", high_bcd, score_bcd); end
  endtask

  task automatic test_display();
    logic [7:0]    seen_seg [DA];
    logic          seen [DA];
    logic [DA-1:0] pat;
    do_reset();
    credit(3);
    pulse_go();
    pulse_clear();
    for (int pass = 0; pass < 2; pass++) begin
      show_high = (pass == 0);
      for (int i = 0; i < int'(DA); i++) begin seen[i] = 1'b0; seen_seg[i] = 8'h00; end
      for (int c = 0; c < int'(2 * DA * WA); c++) begin
        @(negedge clk);
        checks++; if (seg !== m_seg || an !== m_an)
          begin errors++; $display("FAIL disp_scan p%0d: got seg=%h an=%b want seg=%h an=%b", pass, seg, an, m_seg, m_an); end
        for (int i = 0; i < int'(DA); i++) begin
          pat = ~(DA'(1) << i);
          if (an === pat) begin seen[i] = 1'b1; seen_seg[i] = seg; end
        end
      end
      checks++; if (!seen[0] || seen_seg[0] !== 8'hC0) begin errors++; $display("FAIL disp_d0 p%0d: got %h want c0", pass, seen_seg[0]); end
      if (pass == 0) begin
        checks++; if (!seen[1] || seen_seg[1] !== 8'hB0) begin errors++; $display("FAIL disp_high_d1: got %h want b0", seen_seg[1]); end
      end else begin
        checks++; if (seen[1]) begin errors++; $display("FAIL disp_score_d1: got lit want blank"); end
      end
    end
    show_high = 1'b0;
  endtask

  task automatic test_saturation();
    int busy_cnt = 0;
    logic [31:0] b32;
    hit_b = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      hit_b = 1'b0;
      if (k == 0) hit_b = 1'b1;
      if (busy_b === 1'b1) busy_cnt++;
      b32 = to_bcd(mb_score);
      checks++; if (score_b !== b32[7:0] || ovf_b !== mb_ovf)
        begin errors++; $display("FAIL sat_track k%0d: got score=%h ovf=%b want %h %b", k, score_b, ovf_b, b32[7:0], mb_ovf); end
    end
    checks++; if (busy_cnt != 256) begin errors++; $display("FAIL sat_pending: got busy cycles %0d want 256", busy_cnt); end
    checks++; if (score_b !== 8'h99 || ovf_b !== 1'b1)
      begin errors++; $display("FAIL sat_ceiling: got score=%h ovf=%b want 99 1", score_b, ovf_b); end
    clear_b = 1'b1; @(negedge clk); clear_b = 1'b0;
    checks++; if (ovf_b !== 1'b0 || score_b !== 8'h00)
      begin errors++; $display("FAIL sat_clear: got score=%h ovf=%b want 00 0", score_b, ovf_b); end
  endtask

  task automatic test_random();
    logic [31:0] b32, bb;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      b32 = to_bcd(m_score);
      checks++; if (score_bcd !== b32[15:0]) begin errors++; $display("FAIL rnd_score k%0d: got %h want %h", k, score_bcd, b32[15:0]); end
      b32 = to_bcd(m_high);
      checks++; if (high_bcd !== b32[15:0]) begin errors++; $display("FAIL rnd_high k%0d: got %h want %h", k, high_bcd, b32[15:0]); end
      checks++; if (busy !== (m_pend != 0) || overflow !== m_ovf)
        begin errors++; $display("FAIL rnd_flags k%0d: got busy=%b ovf=%b want %b %b", k, busy, overflow, m_pend != 0, m_ovf); end
      checks++; if (seg !== m_seg || an !== m_an)
        begin errors++; $display("FAIL rnd_disp k%0d: got seg=%h an=%b want seg=%h an=%b", k, seg, an, m_seg, m_an); end
      bb = to_bcd(mb_score);
      checks++; if (score_b !== bb[7:0] || busy_b !== (mb_pend != 0) || ovf_b !== mb_ovf)
        begin errors++; $display("FAIL rnd_b k%0d: got %h %b %b want %h %b %b", k, score_b, busy_b, ovf_b, bb[7:0], mb_pend != 0, mb_ovf); end
      reset_n     = ($urandom_range(199) != 0);
      hit         = ($urandom_range(3) == 0);
      clear_score = ($urandom_range(59) == 0);
      game_over   = ($urandom_range(19) == 0);
      if ($urandom_range(15) == 0) show_high = ~show_high;
      hit_b       = ($urandom_range(49) == 0);
      clear_b     = ($urandom_range(149) == 0);
    end
    reset_n = 1'b1; hit = 1'b0; clear_score = 1'b0; game_over = 1'b0; hit_b = 1'b0; clear_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_high_score();
    test_display();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
